// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the push-button event generator.
// State encodings are also decoded by the menu FSMs that watch held/events.
package button_event_gen_pkg;

   typedef enum logic [1:0] {
      BTN_IDLE    = 2'd0,
      BTN_PRESSED = 2'd1,
      BTN_LONG    = 2'd2
   } btn_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/button_event_gen_edge_detect.sv
// Registered copy of a synchronous level plus its rising/falling edges.
// Reusable for any level already synchronous to clk.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic q_q;

   always_ff @(posedge clk) begin
      if (rst) q_q <= 1'b0;
      else     q_q <= d;
   end

   assign q    = q_q;
   assign rise = d & ~q_q;
   assign fall = ~d & q_q;

endmodule

// File: rtl/button_event_gen.sv
// Turns one debounced button level into press/release/click/long/repeat
// pulses plus a held level; one instance per button.
module button_event_gen
   import button_event_gen_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = 200,
   parameter int unsigned REPEAT_CYCLES = 50,
   parameter int unsigned CNT_W         = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_level,
   input  logic en,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  =
      CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
   localparam logic             REP_EN    = (REPEAT_CYCLES != 0);

   btn_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             arm_q;
   logic             press_q, rel_q, click_q, long_q, rep_q, held_q;
   logic             pb_q, pb_rise, pb_fall;

   edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (pb_level),
      .q    (pb_q),
      .rise (pb_rise),
      .fall (pb_fall)
   );

   // pb_q is forced low by reset, so the first "rise" after reset is not a
   // real edge; arm_q masks it until a low registered level has been seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BTN_IDLE;
         cnt_q   <= '0;
         arm_q   <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         click_q <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         arm_q   <= arm_q | ~pb_q;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         click_q <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         if (!en) begin
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
         end else begin
            unique case (state_q)
               BTN_IDLE: begin
                  if (pb_rise && arm_q) begin
                     state_q <= BTN_PRESSED;
                     cnt_q   <= '0;
                     press_q <= 1'b1;
                     held_q  <= 1'b1;
                  end
               end
               BTN_PRESSED: begin
                  // pb_q is always 1 while held, so fall == !pb_level here
                  if (pb_fall) begin
                     state_q <= BTN_IDLE;
                     rel_q   <= 1'b1;
                     click_q <= 1'b1;
                     held_q  <= 1'b0;
                  end else if (cnt_q == LONG_LAST) begin
                     state_q <= BTN_LONG;
                     cnt_q   <= '0;
                     long_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               BTN_LONG: begin
                  if (pb_fall) begin
                     state_q <= BTN_IDLE;
                     rel_q   <= 1'b1;
                     held_q  <= 1'b0;
                  end else if (REP_EN && cnt_q == REP_LAST) begin
                     cnt_q <= '0;
                     rep_q <= 1'b1;
                  end else if (cnt_q != '1) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= BTN_IDLE;
                  cnt_q   <= '0;
                  held_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = rel_q;
   assign click_pulse   = click_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = rep_q;
   assign held          = held_q;

endmodule
